// File: rtl/seq_add_pkg.sv
// seq_add_pkg: types and default widths shared by the sequential wide adder.
//   state_e     : controller FSM encoding (IDLE, RUN, DONE)
//   OP_W_DEF    : default operand/result width
//   SLICE_W_DEF : default width of the time-shared adder slice
package seq_add_pkg;

    localparam int unsigned OP_W_DEF    = 64;
    localparam int unsigned SLICE_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_slice.sv
// adder_slice: purely combinational W-bit ripple-carry adder.
//   a, b : W-bit addends
//   ci   : carry in
//   s    : W-bit sum
//   co   : carry out of the MSB
module adder_slice #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    always_comb begin : ripple
        logic c;
        s = '0;
        c = ci;
        for (int unsigned i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/seq_wide_adder_ctrl.sv
// seq_wide_adder_ctrl: performs one OP_W-bit add over NSLICE = OP_W/SLICE_W
// cycles by time-sharing a single SLICE_W-bit ripple adder, LSB slice first,
// with the inter-slice carry held in a register.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (accepted only in IDLE)
//   a, b, cin         : operands, sampled only at acceptance
//   out_valid/out_ready : result handshake (held in DONE until taken)
//   sum, cout         : result and carry out of the MSB slice
//   busy              : high in RUN or DONE
// Optional feature macro SEQ_ADD_SUB_EN adds input op_sub: when set at
// acceptance the operation is a - b (cin ignored, cout=1 means no borrow).
// OP_W must be an integer multiple of SLICE_W.
module seq_wide_adder_ctrl
    import seq_add_pkg::*;
#(
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned SLICE_W = SLICE_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            cin,
`ifdef SEQ_ADD_SUB_EN
    input  logic            op_sub,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] sum,
    output logic            cout,
    output logic            busy
);

    localparam int unsigned NSLICE = OP_W / SLICE_W;
    // Keep the counter at least one bit wide when there is a single slice.
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   slice_idx_q, slice_idx_d;
    logic               carry_q, carry_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [OP_W-1:0]    sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SEQ_ADD_SUB_EN
    logic               sub_q, sub_d;
`endif

    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_co;

    // Operand slice selection; subtraction feeds the inverted B slice and
    // relies on the initial carry of 1 to form the two's complement.
    always_comb begin
        slice_a = a_q[slice_idx_q * SLICE_W +: SLICE_W];
        slice_b = b_q[slice_idx_q * SLICE_W +: SLICE_W];
`ifdef SEQ_ADD_SUB_EN
        if (sub_q) begin
            slice_b = ~slice_b;
        end
`endif
    end

    adder_slice #(
        .W (SLICE_W)
    ) u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d     = state_q;
        slice_idx_d = slice_idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
`ifdef SEQ_ADD_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d         = a;
                    b_d         = b;
                    slice_idx_d = '0;
`ifdef SEQ_ADD_SUB_EN
                    sub_d       = op_sub;
                    carry_d     = op_sub ? 1'b1 : cin;
`else
                    carry_d     = cin;
`endif
                    state_d     = RUN;
                end
            end
            RUN: begin
                sum_d[slice_idx_q * SLICE_W +: SLICE_W] = slice_s;
                carry_d = slice_co;
                if (slice_idx_q == CNT_W'(NSLICE - 1)) begin
                    cout_d      = slice_co;
                    slice_idx_d = '0;
                    state_d     = DONE;
                end else begin
                    slice_idx_d = slice_idx_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slice_idx_q <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slice_idx_q <= slice_idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
`ifdef SEQ_ADD_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// tb_seq_wide_adder_ctrl: table-driven bench for seq_wide_adder_ctrl with
// hand-written sequences for backpressure and mid-operation reset.
module tb_seq_wide_adder_ctrl;

    localparam int unsigned OP_W    = 64;
    localparam int unsigned SLICE_W = 16;
    localparam int unsigned NSLICE  = OP_W / SLICE_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            cin;
`ifdef SEQ_ADD_SUB_EN
    logic            op_sub;
`endif
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] sum;
    logic            cout;
    logic            busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_wide_adder_ctrl #(
        .OP_W    (OP_W),
        .SLICE_W (SLICE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SEQ_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic        early_ready;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // One full operation: accept, count RUN latency, check result, hand off.
    task automatic do_op(input vec_t v, input string nm);
        int lat;
        @(negedge clk);
        chk({nm, " in_ready idle"}, {64'd0, in_ready}, 65'd1);
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
`ifdef SEQ_ADD_SUB_EN
        op_sub    = v.sub;
`endif
        in_valid  = 1'b1;
        out_ready = v.early_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~v.a;
        b        = ~v.b;
        cin      = ~v.cin;
        chk({nm, " busy run"}, {64'd0, busy}, 65'd1);
        chk({nm, " in_ready run"}, {64'd0, in_ready}, 65'd0);
        chk({nm, " out_valid run"}, {64'd0, out_valid}, 65'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 65'(lat), 65'(NSLICE));
        chk({nm, " sum"}, {1'b0, sum}, {1'b0, v.sum});
        chk({nm, " cout"}, {64'd0, cout}, {64'd0, v.cout});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({nm, " out_valid after"}, {64'd0, out_valid}, 65'd0);
        chk({nm, " in_ready after"}, {64'd0, in_ready}, 65'd1);
        chk({nm, " busy after"}, {64'd0, busy}, 65'd0);
        out_ready = 1'b0;
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 1'b0,
                    64'h0000_0000_0000_0008, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b0,
                    64'h0000_0000_0000_0000, 1'b1};
        vecs[2] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 1'b1,
                    64'h0001_0000_0001_0000, 1'b0};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1,
                    64'h0000_0000_0000_0000, 1'b1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0,
                    64'h0000_0000_0000_0000, 1'b1};
        vecs[7] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b0,
                    64'h0000_0000_0000_0000, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SEQ_ADD_SUB_EN
        op_sub    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", {64'd0, in_ready}, 65'd1);
        chk("reset out_valid", {64'd0, out_valid}, 65'd0);
        chk("reset busy", {64'd0, busy}, 65'd0);
        chk("reset sum", {1'b0, sum}, 65'd0);
        chk("reset cout", {64'd0, cout}, 65'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: DONE held with out_ready low while inputs churn.
        v = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0, 1'b0, 1'b0,
              64'h0000_0000_0000_0008, 1'b0};
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NSLICE) @(posedge clk);
        @(negedge clk);
        chk("bp out_valid", {64'd0, out_valid}, 65'd1);
        for (int k = 0; k < 10; k++) begin
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            cin      = k[0];
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp sum %0d", k), {1'b0, sum}, 65'h8);
            chk($sformatf("bp in_ready %0d", k), {64'd0, in_ready}, 65'd0);
            chk($sformatf("bp out_valid %0d", k), {64'd0, out_valid}, 65'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp release out_valid", {64'd0, out_valid}, 65'd0);
        chk("bp release in_ready", {64'd0, in_ready}, 65'd1);
        chk("bp release busy", {64'd0, busy}, 65'd0);
        // out_ready high in IDLE must not create activity.
        @(posedge clk);
        @(negedge clk);
        chk("bp idle busy", {64'd0, busy}, 65'd0);
        chk("bp idle sum", {1'b0, sum}, 65'h8);
        out_ready = 1'b0;

        // Reset during the second RUN cycle aborts the operation.
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort sum partial", {1'b0, sum}, 65'h2211);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort out_valid", {64'd0, out_valid}, 65'd0);
        chk("abort sum", {1'b0, sum}, 65'd0);
        chk("abort busy", {64'd0, busy}, 65'd0);
        chk("abort in_ready", {64'd0, in_ready}, 65'd1);
        chk("abort cout", {64'd0, cout}, 65'd0);
        rst = 1'b0;
        do_op(vecs[2], "post abort");

`ifdef SEQ_ADD_SUB_EN
        v = '{64'd5, 64'd7, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        do_op(v, "sub 5-7");
        v = '{64'd7, 64'd5, 1'b1, 1'b1, 1'b0, 64'd2, 1'b1};
        do_op(v, "sub 7-5");
        v = '{64'd7, 64'd5, 1'b1, 1'b0, 1'b0, 64'd13, 1'b0};
        do_op(v, "add mode");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
